// File: rtl/qwi12_led_pkg.sv
// qwi12_led_pkg: shared types and widths for the LED sequencer.
// Optional feature macro: QWI12_LED_BREATHE_EN (enables BREATHE mode / PWM).
package qwi12_led_pkg;

    localparam int unsigned LED_MODE_W = 3;
    localparam int unsigned RATE_W     = 8;

    typedef enum logic [2:0] {
        LED_OFF     = 3'd0,
        LED_DIRECT  = 3'd1,
        LED_BLINK   = 3'd2,
        LED_CHASE   = 3'd3,
        LED_BREATHE = 3'd4
    } led_mode_t;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } led_state_t;

    // Map a raw mode code onto a supported mode; anything unsupported becomes OFF.
    function automatic led_mode_t mode_norm(input logic [LED_MODE_W-1:0] m);
        led_mode_t r;
        r = LED_OFF;
        case (m)
            3'd1: r = LED_DIRECT;
            3'd2: r = LED_BLINK;
            3'd3: r = LED_CHASE;
`ifdef QWI12_LED_BREATHE_EN
            3'd4: r = LED_BREATHE;
`endif
            default: r = LED_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qwi12_led_sequencer_if.sv
// qwi12_led_sequencer_if: valid/ready configuration port (mode + rate).
interface qwi12_led_sequencer_if;
    import qwi12_led_pkg::*;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [LED_MODE_W-1:0] cfg_mode;
    logic [RATE_W-1:0]     cfg_rate;

    modport master (output cfg_valid, output cfg_mode, output cfg_rate, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_mode, input cfg_rate, output cfg_ready);
endinterface

// File: rtl/qwi12_led_pwm.sv
// qwi12_led_pwm: triangle duty counter plus free-running PWM compare for BREATHE.
// Only instantiated when QWI12_LED_BREATHE_EN is defined.
module qwi12_led_pwm #(
    parameter int unsigned PWM_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step_en,
    output logic pwm_o
);
    localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] duty_q;
    logic             up_q;

    // Duty ramps up/down one per step, holding each end value for one step; compare is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            up_q   <= 1'b1;
            pwm_o  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + PWM_W'(1);
            pwm_o <= (cnt_q < duty_q);
            if (clr) begin
                duty_q <= '0;
                up_q   <= 1'b1;
            end else if (step_en) begin
                if (up_q) begin
                    if (duty_q == DUTY_MAX) up_q <= 1'b0;
                    else                    duty_q <= duty_q + PWM_W'(1);
                end else begin
                    if (duty_q == '0) up_q <= 1'b1;
                    else              duty_q <= duty_q - PWM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/qwi12_led_sequencer.sv
// qwi12_led_sequencer: owns the board LEDs; GPIO passthrough or blink/chase/breathe patterns.
// Optional feature macro: QWI12_LED_BREATHE_EN (mode 4 BREATHE; otherwise mode 4 is reserved).
module qwi12_led_sequencer
    import qwi12_led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    qwi12_led_sequencer_if.slave  cfg,
    input  logic [N_LED-1:0]      gpio_led,
    output logic [N_LED-1:0]      led,
    output logic                  step
);
    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    // Elaboration-time guard on parameter ranges.
    if (N_LED < 2 || TICK_DIV < 2 || PWM_W < 1) begin : g_param_check
        $error("qwi12_led_sequencer: unsupported parameter values");
    end

    led_state_t          state_q;
    led_mode_t           mode_q;
    logic [RATE_W-1:0]   rate_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [RATE_W-1:0]   step_cnt_q;
    logic                phase_q;
    logic [N_LED-1:0]    chase_q;
    logic [N_LED-1:0]    led_q;
    logic                step_q;
    logic                cfg_ready_q;

    logic                accept_c;
    logic                tick_c;
    logic                step_evt_c;
    logic                phase_d;
    logic [N_LED-1:0]    chase_d;
    logic [N_LED-1:0]    led_d;

`ifdef QWI12_LED_BREATHE_EN
    logic pwm_c;
    logic pwm_clr_c;
    logic pwm_step_c;

    assign pwm_clr_c  = accept_c | (state_q == S_LOAD);
    assign pwm_step_c = step_evt_c & (mode_q == LED_BREATHE);

    qwi12_led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk     (clk),
        .rst     (rst),
        .clr     (pwm_clr_c),
        .step_en (pwm_step_c),
        .pwm_o   (pwm_c)
    );
`endif

    // Handshake, tick/step detection and next pattern state; an accept suppresses a coincident step.
    always_comb begin
        accept_c   = cfg.cfg_valid & cfg_ready_q;
        tick_c     = (presc_q == PRESC_MAX);
        step_evt_c = (state_q == S_RUN) && tick_c && (step_cnt_q == rate_q) && !accept_c;
        phase_d    = phase_q ^ step_evt_c;
        chase_d    = step_evt_c ? {chase_q[N_LED-2:0], chase_q[N_LED-1]} : chase_q;
        led_d      = '0;
        case (mode_q)
            LED_DIRECT:  led_d = gpio_led;
            LED_BLINK:   led_d = {N_LED{phase_d}};
            LED_CHASE:   led_d = chase_d;
`ifdef QWI12_LED_BREATHE_EN
            LED_BREATHE: led_d = {N_LED{pwm_c}};
`endif
            default:     led_d = '0;
        endcase
    end

    // FSM with prescaler, step counter, pattern state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            mode_q      <= LED_OFF;
            rate_q      <= '0;
            presc_q     <= '0;
            step_cnt_q  <= '0;
            phase_q     <= 1'b0;
            chase_q     <= N_LED'(1);
            led_q       <= '0;
            step_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            cfg_ready_q <= ~accept_c;
            step_q      <= 1'b0;
            if (accept_c) begin
                state_q    <= S_LOAD;
                mode_q     <= mode_norm(cfg.cfg_mode);
                rate_q     <= cfg.cfg_rate;
                presc_q    <= '0;
                step_cnt_q <= '0;
                phase_q    <= 1'b0;
                chase_q    <= N_LED'(1);
                led_q      <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        state_q    <= (mode_q == LED_OFF) ? S_OFF : S_RUN;
                        presc_q    <= '0;
                        step_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        chase_q    <= N_LED'(1);
                        led_q      <= (mode_q == LED_OFF) ? '0 : led_d;
                    end
                    S_RUN: begin
                        presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
                        if (tick_c) begin
                            step_cnt_q <= (step_cnt_q == rate_q) ? '0 : step_cnt_q + RATE_W'(1);
                        end
                        phase_q <= phase_d;
                        chase_q <= chase_d;
                        led_q   <= led_d;
                        step_q  <= step_evt_c;
                    end
                    default: begin
                        state_q <= S_OFF;
                        presc_q <= '0;
                        led_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign led           = led_q;
    assign step          = step_q;

endmodule

// File: tb/tb_qwi12_led_sequencer.sv
// tb_qwi12_led_sequencer: directed bench for the LED sequencer (N_LED=4, TICK_DIV=4, PWM_W=8).
module tb_qwi12_led_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] gpio_led;
    logic [3:0] led;
    logic       step;

    int errors = 0;
    int checks = 0;

    qwi12_led_sequencer_if cfg_if ();

    qwi12_led_sequencer #(.N_LED(4), .TICK_DIV(4), .PWM_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg_if),
        .gpio_led (gpio_led),
        .led      (led),
        .step     (step)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle config transfer; returns in the first cycle after S_LOAD.
    task automatic load(input logic [2:0] mode, input logic [7:0] rate);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_rate  = rate;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        chk("load_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        cyc();
    endtask

    initial begin
        int nstep;
        int on_cnt;
        logic [3:0] exp_chase [4];
        exp_chase[0] = 4'b0010; exp_chase[1] = 4'b0100;
        exp_chase[2] = 4'b1000; exp_chase[3] = 4'b0001;

        clk = 1'b0;
        rst = 1'b1;
        gpio_led = 4'b0000;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_mode  = 3'd0;
        cfg_if.cfg_rate  = 8'd0;

        // 1. Reset
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_step", 32'(step), 32'd0);
        nstep = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (step) nstep++;
        end
        chk("rst_no_steps", 32'(nstep), 32'd0);
        chk("rst_led_idle", 32'(led), 32'h0);

        // 2. DIRECT
        load(3'd1, 8'd0);
        gpio_led = 4'b1010;
        chk("direct_latency", 32'(led), 32'h0);
        cyc();
        chk("direct_1010", 32'(led), 32'hA);
        gpio_led = 4'b0101;
        cyc();
        chk("direct_0101", 32'(led), 32'h5);

        // 3. CHASE rate=1: 8-cycle steps
        load(3'd3, 8'd1);
        chk("chase_init", 32'(led), 32'h1);
        chk("chase_init_step", 32'(step), 32'd0);
        for (int s = 0; s < 4; s++) begin
            repeat (7) cyc();
            chk("chase_hold_step", 32'(step), 32'd0);
            cyc();
            chk("chase_led", 32'(led), 32'(exp_chase[s]));
            chk("chase_step", 32'(step), 32'd1);
        end

        // Valid held through S_LOAD: no accept there, accepted again right after.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = 3'd3;
        cfg_if.cfg_rate  = 8'd1;
        cyc();
        chk("hold_load_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("hold_load_led", 32'(led), 32'h0);
        cyc();
        chk("hold_run_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("hold_run_led", 32'(led), 32'h1);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        chk("reaccept_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("reaccept_led", 32'(led), 32'h0);
        cyc();
        chk("reload_restart", 32'(led), 32'h1);

        // 4. BLINK rate=0: toggle every 4 cycles
        load(3'd2, 8'd0);
        chk("blink_init", 32'(led), 32'h0);
        repeat (3) cyc();
        chk("blink_pre_on", 32'(led), 32'h0);
        cyc();
        chk("blink_on", 32'(led), 32'hF);
        chk("blink_on_step", 32'(step), 32'd1);
        repeat (3) cyc();
        chk("blink_pre_off", 32'(led), 32'hF);
        cyc();
        chk("blink_off", 32'(led), 32'h0);
        chk("blink_off_step", 32'(step), 32'd1);
        // Accept exactly on the next step-event cycle: step is dropped.
        repeat (3) cyc();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode  = 3'd0;
        cfg_if.cfg_rate  = 8'd0;
        cyc();
        cfg_if.cfg_valid = 1'b0;
        chk("collide_step", 32'(step), 32'd0);
        chk("collide_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("collide_led", 32'(led), 32'h0);
        cyc();
        chk("collide_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        nstep = 0;
        on_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (step) nstep++;
            if (led != 4'b0000) on_cnt++;
        end
        chk("off_no_steps", 32'(nstep), 32'd0);
        chk("off_led", 32'(on_cnt), 32'd0);

        // 5. BREATHE
`ifdef QWI12_LED_BREATHE_EN
        load(3'd4, 8'd0);
        nstep = 0;
        for (int i = 0; i < 1100 && nstep < 255; i++) begin
            cyc();
            if (step) nstep++;
        end
        chk("breathe_steps", 32'(nstep), 32'd255);
        chk("breathe_duty_max", 32'(dut.u_pwm.duty_q), 32'd255);
        // Slow rate: duty 0 for the first 1024 cycles, then 1.
        load(3'd4, 8'd255);
        repeat (8) cyc();
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (led == 4'b1111) on_cnt++;
        end
        chk("breathe_duty0_on", 32'(on_cnt), 32'd0);
        nstep = 0;
        for (int i = 0; i < 1100 && nstep == 0; i++) begin
            cyc();
            if (step) nstep++;
        end
        chk("breathe_first_step", 32'(nstep), 32'd1);
        repeat (4) cyc();
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (led == 4'b1111) on_cnt++;
        end
        chk("breathe_duty1_on", 32'(on_cnt <= 2 && on_cnt >= 0), 32'd1);
        chk("breathe_duty1_nonzero", 32'(on_cnt >= 1), 32'd1);
`else
        load(3'd4, 8'd0);
        chk("breathe_off_led", 32'(led), 32'h0);
        chk("breathe_off_ready", 32'(cfg_if.cfg_ready), 32'd1);
        nstep = 0;
        on_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (step) nstep++;
            if (led != 4'b0000) on_cnt++;
        end
        chk("breathe_off_steps", 32'(nstep), 32'd0);
        chk("breathe_off_led_idle", 32'(on_cnt), 32'd0);
`endif

        // 6. Reset mid-CHASE at led=0100
        load(3'd3, 8'd1);
        repeat (16) cyc();
        chk("midrst_pre", 32'(led), 32'h4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_led", 32'(led), 32'h0);
        chk("midrst_step", 32'(step), 32'd0);
        chk("midrst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        nstep = 0;
        on_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (step) nstep++;
            if (led != 4'b0000) on_cnt++;
        end
        chk("midrst_idle_steps", 32'(nstep), 32'd0);
        chk("midrst_idle_led", 32'(on_cnt), 32'd0);
        load(3'd3, 8'd1);
        chk("midrst_restart", 32'(led), 32'h1);
        repeat (8) cyc();
        chk("midrst_restart_step", 32'(led), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
